// File: rtl/opb_register_bank_ppc2simulink_if.sv
// OPB slave-side bus bundle. Vectors use [31:0]; OPB bit 0 (the MSB) is index 31,
// so OPB_DBus[k] is index 31-k and OPB_BE[b] is index 3-b.
interface opb_register_bank_ppc2simulink_if;
  logic [31:0] OPB_ABus;
  logic [3:0]  OPB_BE;
  logic [31:0] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [31:0] Sl_DBus;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;
  logic        Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave exposing a bank of 32-bit software registers to the fabric, with
// byte-enable writes, read-only and self-clearing registers, and write strobes.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h01000A00,
  parameter logic [31:0] C_HIGHADDR   = 32'h01000AFF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned C_NUM_REGS   = 4,
  parameter logic [63:0] C_RO_MASK    = 64'h0,
  parameter logic [63:0] C_PULSE_MASK = 64'h0,
  parameter logic [31:0] C_RESET_VAL  = 32'h0,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst_n,
  opb_register_bank_ppc2simulink_if.slave bus,
  output logic [32*C_NUM_REGS-1:0]   user_data_out,
  input  logic [32*C_NUM_REGS-1:0]   user_data_in,
  output logic [C_NUM_REGS-1:0]      user_wr_strobe
);

  localparam int unsigned NR = C_NUM_REGS;
  localparam int unsigned RW = 32 * NR;

  typedef enum logic [1:0] {IDLE, ACK, HOLD} state_t;

  state_t          state_q;
  logic [RW-1:0]   regs_q;
  logic [31:0]     rdata_q;
  logic            ack_q;
  logic [NR-1:0]   strobe_q;

  logic [31:0]     offset_c;
  logic [31:0]     bmask_c;
  logic [31:0]     rd_c;
  logic            hit_c;
  logic [NR-1:0]   sel_c;
  logic            unused_c;

  // Window decode, byte mask and read mux; unmapped words select nothing and read 0
  always_comb begin
    hit_c    = bus.OPB_select && (bus.OPB_ABus >= C_BASEADDR) && (bus.OPB_ABus <= C_HIGHADDR);
    offset_c = bus.OPB_ABus - C_BASEADDR;
    bmask_c  = '0;
    for (int b = 0; b < 4; b++) begin
      bmask_c[8*b +: 8] = {8{bus.OPB_BE[b]}};
    end
    sel_c = '0;
    rd_c  = '0;
    for (int i = 0; i < int'(NR); i++) begin
      if (offset_c[31:2] == 30'(i)) begin
        sel_c[i] = 1'b1;
        rd_c     = C_RO_MASK[i] ? user_data_in[32*i +: 32] : regs_q[32*i +: 32];
      end
    end
  end

  assign unused_c = &{1'b0, bus.OPB_seqAddr, offset_c[1:0]};

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      strobe_q <= '0;
      regs_q   <= {NR{C_RESET_VAL}};
    end else begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      strobe_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (hit_c) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            if (bus.OPB_RNW) begin
              rdata_q <= rd_c;
            end else begin
              for (int i = 0; i < int'(NR); i++) begin
                if (sel_c[i] && !C_RO_MASK[i]) begin
                  regs_q[32*i +: 32] <= (regs_q[32*i +: 32] & ~bmask_c) |
                                        (bus.OPB_DBus & bmask_c);
                  strobe_q[i]        <= 1'b1;
                end
              end
            end
          end
        end
        ACK: begin
          state_q <= bus.OPB_select ? HOLD : IDLE;
          // Pulse registers written in the previous cycle fall back to their clear value
          for (int i = 0; i < int'(NR); i++) begin
            if (strobe_q[i] && C_PULSE_MASK[i]) begin
              regs_q[32*i +: 32] <= C_RESET_VAL;
            end
          end
        end
        HOLD: begin
          if (!bus.OPB_select) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Sl_DBus    = rdata_q;
  assign bus.Sl_xferAck = ack_q;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;
  assign user_data_out  = regs_q;
  assign user_wr_strobe = strobe_q;

endmodule
